// File: rtl/mesh_node_interface.sv
// Local-port injection/ejection stage for a mesh router: formats node flits into a TX FIFO and buffers router deliveries in an RX FIFO.
// Define MESH_NODE_STATS_EN to add the saturating txCount/rxCount/dropCount statistics outputs.
module mesh_node_interface #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 4,
  parameter int TX_DEPTH   = 4,
  parameter int RX_DEPTH   = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                nodeWrReq,
  input  logic [ADDR_BITS-1:0]                nodeDestX,
  input  logic [ADDR_BITS-1:0]                nodeDestY,
  input  logic [DATA_WIDTH-2*ADDR_BITS-2:0]   nodePayload,
  output logic                                nodeWrReady,
  output logic [DATA_WIDTH-1:0]               txData,
  output logic                                txReq,
  input  logic                                txHold,
  input  logic [DATA_WIDTH-1:0]               rxData,
  input  logic                                rxReq,
  output logic                                rxHold,
  output logic [DATA_WIDTH-1:0]               nodeRxData,
  output logic                                nodeRxValid,
  input  logic                                nodeRxAck,
  output logic                                rxOverflow
`ifdef MESH_NODE_STATS_EN
  ,
  output logic [15:0]                         txCount,
  output logic [15:0]                         rxCount,
  output logic [15:0]                         dropCount
`endif
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_DEPTH);
  localparam logic [RX_AW:0] RX_HIGH = (RX_AW+1)'(RX_DEPTH - 1);

  // ---------------- Injection path ----------------
  logic [DATA_WIDTH-1:0] txMem [TX_DEPTH];
  logic [TX_AW-1:0]      txWrPtr, txRdPtr;
  logic [TX_AW:0]        txCnt;
  logic                  txPush, txPop;

  // Ready comes from the registered count, so a same-cycle pop never frees room for a push.
  assign nodeWrReady = (txCnt != TX_FULL);
  assign txPush      = nodeWrReq && nodeWrReady;
  assign txPop       = (txCnt != '0) && !txHold;

  // NOTE: FIFO storage carries no reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (txPush) txMem[txWrPtr] <= {1'b1, nodeDestX, nodeDestY, nodePayload};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txWrPtr <= '0;
      txRdPtr <= '0;
      txCnt   <= '0;
      txData  <= '0;
      txReq   <= 1'b0;
    end else begin
      txReq <= txPop;
      if (txPush) txWrPtr <= txWrPtr + 1'b1;
      if (txPop) begin
        txRdPtr <= txRdPtr + 1'b1;
        txData  <= txMem[txRdPtr];
      end
      case ({txPush, txPop})
        2'b10:   txCnt <= txCnt + 1'b1;
        2'b01:   txCnt <= txCnt - 1'b1;
        default: txCnt <= txCnt;
      endcase
    end
  end

  // ---------------- Ejection path ----------------
  logic [DATA_WIDTH-1:0] rxMem [RX_DEPTH];
  logic [RX_AW-1:0]      rxWrPtr, rxRdPtr;
  logic [RX_AW:0]        rxCnt, rxCntNext;
  logic                  rxFlitIn, rxFull, rxPush, rxPop, rxDrop;

  assign rxFlitIn    = rxReq && rxData[DATA_WIDTH-1];
  assign rxFull      = (rxCnt == RX_FULL);
  assign rxPop       = nodeRxAck && (rxCnt != '0);
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign rxPush      = rxFlitIn && (!rxFull || rxPop);
  assign rxDrop      = rxFlitIn && rxFull && !rxPop;
  assign nodeRxData  = rxMem[rxRdPtr];
  assign nodeRxValid = (rxCnt != '0);

  // NOTE: every variable assigned in always_comb gets its default first so no latch is inferred.
  always_comb begin
    rxCntNext = rxCnt;
    if (rxPush && !rxPop)      rxCntNext = rxCnt + 1'b1;
    else if (!rxPush && rxPop) rxCntNext = rxCnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rxPush) rxMem[rxWrPtr] <= rxData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxWrPtr    <= '0;
      rxRdPtr    <= '0;
      rxCnt      <= '0;
      rxHold     <= 1'b0;
      rxOverflow <= 1'b0;
    end else begin
      if (rxPush) rxWrPtr <= rxWrPtr + 1'b1;
      if (rxPop)  rxRdPtr <= rxRdPtr + 1'b1;
      rxCnt <= rxCntNext;
      // Hold rises one slot early to absorb a flit the router already has in flight.
      rxHold <= (rxCntNext >= RX_HIGH);
      if (rxDrop) rxOverflow <= 1'b1;
    end
  end

`ifdef MESH_NODE_STATS_EN
  // ---------------- Saturating statistics ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txCount   <= '0;
      rxCount   <= '0;
      dropCount <= '0;
    end else begin
      if (txPop  && txCount   != 16'hFFFF) txCount   <= txCount + 1'b1;
      if (rxPush && rxCount   != 16'hFFFF) rxCount   <= rxCount + 1'b1;
      if (rxDrop && dropCount != 16'hFFFF) dropCount <= dropCount + 1'b1;
    end
  end
`endif

endmodule
